// File: rtl/memory_access_controller_if.sv
// Handshake bundle between the control unit (master) and the memory access controller (slave).
interface memory_access_controller_if;
   logic in_start;
   logic in_rw;
   logic in_mem_ready;
   logic out_mar_load;
   logic out_mdr_write;
   logic out_mdr_read;
   logic out_mem_read;
   logic out_mem_write;
   logic out_busy;
   logic out_done;
   logic out_error;

   modport master (
      output in_start, in_rw, in_mem_ready,
      input  out_mar_load, out_mdr_write, out_mdr_read, out_mem_read,
             out_mem_write, out_busy, out_done, out_error
   );

   modport slave (
      input  in_start, in_rw, in_mem_ready,
      output out_mar_load, out_mdr_write, out_mdr_read, out_mem_read,
             out_mem_write, out_busy, out_done, out_error
   );
endinterface

// File: rtl/memory_access_controller.sv
// Memory access sequencer: IDLE -> ADDR -> ACCESS -> (LATCH) -> DONE, Moore outputs.
// Optional ACCESS timeout abort enabled by defining MEM_TIMEOUT_EN.
module memory_access_controller #(
   parameter int unsigned WAIT_STATES    = 1,
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input logic                        in_clk,
   input logic                        in_clr,
   memory_access_controller_if.slave  bus
);

   if (WAIT_STATES > 255) begin : g_wait_range
      $error("WAIT_STATES must be 0..255");
   end
   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_timeout_range
      $error("TIMEOUT_CYCLES must be 1..255");
   end

   typedef enum logic [2:0] {
      IDLE,
      ADDR,
      ACCESS,
      LATCH,
      DONE
   } state_t;

   localparam logic [7:0] WAIT_LIM = 8'(WAIT_STATES);

   state_t     state;
   state_t     state_nx;
   logic       op;
   logic [7:0] wait_cnt;
   logic       access_exit;

   assign access_exit = bus.in_mem_ready && (wait_cnt >= WAIT_LIM);

`ifdef MEM_TIMEOUT_EN
   localparam logic [7:0] TO_LIM = 8'(TIMEOUT_CYCLES - 1);

   logic [7:0] to_cnt;
   logic       timeout_hit;
   logic       err;

   // timeout_hit is evaluated during the TIMEOUT_CYCLES-th ACCESS cycle
   assign timeout_hit = (to_cnt == TO_LIM);

   always_ff @(posedge in_clk) begin
      if (in_clr) begin
         to_cnt <= '0;
         err    <= 1'b0;
      end else begin
         case (state)
            ADDR: begin
               to_cnt <= '0;
               err    <= 1'b0;
            end
            ACCESS: begin
               to_cnt <= to_cnt + 8'd1;
               if (!access_exit && timeout_hit)
                  err <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bus.out_error = (state == DONE) && err;
`else
   assign bus.out_error = 1'b0;
`endif

   always_ff @(posedge in_clk) begin
      if (in_clr) begin
         state    <= IDLE;
         op       <= 1'b0;
         wait_cnt <= '0;
      end else begin
         state <= state_nx;
         if (state == IDLE && bus.in_start)
            op <= bus.in_rw;
         if (state == ADDR)
            wait_cnt <= '0;
         else if (state == ACCESS && wait_cnt != 8'hFF)
            wait_cnt <= wait_cnt + 8'd1;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:   if (bus.in_start) state_nx = ADDR;
         ADDR:   state_nx = ACCESS;
         ACCESS: begin
            if (access_exit)
               state_nx = op ? DONE : LATCH;
`ifdef MEM_TIMEOUT_EN
            else if (timeout_hit)
               state_nx = DONE;
`endif
         end
         LATCH:  state_nx = DONE;
         DONE:   state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   assign bus.out_mar_load  = (state == ADDR);
   assign bus.out_mem_read  = (state == ACCESS) && !op;
   assign bus.out_mem_write = (state == ACCESS) && op;
   assign bus.out_mdr_read  = (state == LATCH);
   assign bus.out_mdr_write = (state == LATCH);
   assign bus.out_busy      = (state != IDLE);
   assign bus.out_done      = (state == DONE);

endmodule

// File: tb/tb_memory_access_controller.sv
// Self-checking bench: three controller instances, traces predicted from transaction rules.
module tb_memory_access_controller;

`ifdef MEM_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   // observed vector: mar_load mdr_write mdr_read mem_read mem_write busy done error
   localparam logic [7:0] V_IDLE = 8'b0000_0000;
   localparam logic [7:0] V_ADDR = 8'b1000_0100;
   localparam logic [7:0] V_RD   = 8'b0001_0100;
   localparam logic [7:0] V_WR   = 8'b0000_1100;
   localparam logic [7:0] V_LAT  = 8'b0110_0100;
   localparam logic [7:0] V_DONE = 8'b0000_0110;
   localparam logic [7:0] V_ERR  = 8'b0000_0111;

   logic clk;
   logic clr;
   logic start;
   logic rw;
   logic ready;
   int   sel;
   int   checks;
   int   passed;

   memory_access_controller_if b0 ();
   memory_access_controller_if b1 ();
   memory_access_controller_if b2 ();

   assign b0.in_start = (sel == 0) && start;
   assign b1.in_start = (sel == 1) && start;
   assign b2.in_start = (sel == 2) && start;
   assign b0.in_mem_ready = (sel == 0) && ready;
   assign b1.in_mem_ready = (sel == 1) && ready;
   assign b2.in_mem_ready = (sel == 2) && ready;
   assign b0.in_rw = rw;
   assign b1.in_rw = rw;
   assign b2.in_rw = rw;

   memory_access_controller #(.WAIT_STATES(0), .TIMEOUT_CYCLES(64)) u_d0 (
      .in_clk(clk), .in_clr(clr), .bus(b0));
   memory_access_controller #(.WAIT_STATES(2), .TIMEOUT_CYCLES(64)) u_d1 (
      .in_clk(clk), .in_clr(clr), .bus(b1));
   memory_access_controller #(.WAIT_STATES(1), .TIMEOUT_CYCLES(4)) u_d2 (
      .in_clk(clk), .in_clr(clr), .bus(b2));

   logic [7:0] obs0, obs1, obs2, obs;
   assign obs0 = {b0.out_mar_load, b0.out_mdr_write, b0.out_mdr_read, b0.out_mem_read,
                  b0.out_mem_write, b0.out_busy, b0.out_done, b0.out_error};
   assign obs1 = {b1.out_mar_load, b1.out_mdr_write, b1.out_mdr_read, b1.out_mem_read,
                  b1.out_mem_write, b1.out_busy, b1.out_done, b1.out_error};
   assign obs2 = {b2.out_mar_load, b2.out_mdr_write, b2.out_mdr_read, b2.out_mem_read,
                  b2.out_mem_write, b2.out_busy, b2.out_done, b2.out_error};
   assign obs = (sel == 0) ? obs0 : (sel == 1) ? obs1 : obs2;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // One transaction on instance s. Ready for access index i is high from index nrdy on
   // (nrdy < 0: random, forced high after 40). Expected trace derived from the rules:
   // ADDR, then ACCESS until ready && index >= ws (or timeout), LATCH for reads, DONE.
   task automatic run_txn(input int s, input bit op, input int ws, input int to,
                          input int nrdy, input bit junk, input string name);
      logic [7:0] expq[$];
      bit         rdy[$];
      bit         err;
      int         i;
      for (int k = 0; k < 200; k++) begin
         if (nrdy >= 0)
            rdy.push_back((k < 2) ? 1'($urandom_range(0, 1)) : (k - 2 >= nrdy));
         else
            rdy.push_back((k >= 42) ? 1'b1 : ($urandom_range(0, 3) == 0));
      end
      expq.push_back(V_ADDR);
      err = 1'b0;
      i = 0;
      forever begin
         expq.push_back(op ? V_WR : V_RD);
         if (rdy[2 + i] && i >= ws) break;
         if (TO_EN && i + 1 >= to) begin
            err = 1'b1;
            break;
         end
         i++;
      end
      if (!op && !err) expq.push_back(V_LAT);
      expq.push_back(err ? V_ERR : V_DONE);

      @(negedge clk);
      sel = s;
      #1;
      checks++;
      if (obs !== V_IDLE)
         $display("FAIL %s idle-before-start: got %b want %b", name, obs, V_IDLE);
      else
         passed++;
      start = 1'b1;
      rw    = op;
      ready = rdy[0];
      for (int c = 1; c <= expq.size(); c++) begin
         @(posedge clk);
         @(negedge clk);
         checks++;
         if (obs !== expq[c - 1])
            $display("FAIL %s cycle %0d: got %b want %b", name, c, obs, expq[c - 1]);
         else
            passed++;
         start = (junk && c < expq.size()) ? 1'($urandom_range(0, 1)) : 1'b0;
         rw    = junk ? 1'($urandom_range(0, 1)) : op;
         ready = rdy[c];
      end
   endtask

   task automatic test_reset();
      clr = 1'b1;
      start = 1'b0;
      ready = 1'b1;
      sel = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      for (int s = 0; s < 3; s++) begin
         sel = s;
         #1;
         checks++;
         if (obs !== V_IDLE)
            $display("FAIL reset_state dut%0d: got %b want %b", s, obs, V_IDLE);
         else
            passed++;
      end
      // reset wins over a simultaneous start
      sel = 0;
      start = 1'b1;
      rw = 1'b0;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (obs !== V_IDLE)
         $display("FAIL reset_priority: got %b want %b", obs, V_IDLE);
      else
         passed++;
      start = 1'b0;
      clr = 1'b0;
   endtask

   task automatic test_reset_access();
      @(negedge clk);
      sel = 0;
      start = 1'b1;
      rw = 1'b0;
      ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (obs !== V_RD)
         $display("FAIL rst_access in_access: got %b want %b", obs, V_RD);
      else
         passed++;
      repeat (2) @(posedge clk);
      @(negedge clk);
      clr = 1'b1;
      start = 1'b1;
      ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      clr = 1'b0;
      start = 1'b0;
      checks++;
      if (obs !== V_IDLE)
         $display("FAIL rst_access after_clr: got %b want %b", obs, V_IDLE);
      else
         passed++;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (obs !== V_IDLE)
         $display("FAIL rst_access no_done: got %b want %b", obs, V_IDLE);
      else
         passed++;
      run_txn(0, 1'b0, 0, 64, 0, 1'b0, "rst_access_recover");
   endtask

   task automatic test_random();
      for (int n = 0; n < 30; n++) begin
         int s;
         s = $urandom_range(0, 1);
         run_txn(s, 1'($urandom_range(0, 1)), (s == 0) ? 0 : 2, 64, -1, 1'b1, "random");
      end
   endtask

   task automatic test_timeout();
`ifdef MEM_TIMEOUT_EN
      run_txn(2, 1'b0, 1, 4, 1000, 1'b1, "timeout_read");
      run_txn(2, 1'b1, 1, 4, 1000, 1'b1, "timeout_write");
`else
      @(negedge clk);
      sel = 2;
      start = 1'b1;
      rw = 1'b0;
      ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      @(posedge clk);
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         checks++;
         if (obs !== V_RD)
            $display("FAIL no_timeout cycle %0d: got %b want %b", c, obs, V_RD);
         else
            passed++;
      end
      clr = 1'b1;
      @(posedge clk);
      @(negedge clk);
      clr = 1'b0;
      checks++;
      if (obs !== V_IDLE)
         $display("FAIL no_timeout clr: got %b want %b", obs, V_IDLE);
      else
         passed++;
`endif
   endtask

   initial begin
      checks = 0;
      passed = 0;
      clr = 1'b1;
      start = 1'b0;
      rw = 1'b0;
      ready = 1'b0;
      sel = 0;
      test_reset();
      run_txn(0, 1'b0, 0, 64, 0, 1'b0, "read_ws0");
      run_txn(1, 1'b1, 2, 64, 0, 1'b0, "write_ws2");
      run_txn(0, 1'b0, 0, 64, 6, 1'b1, "slow_read");
      run_txn(0, 1'b1, 0, 64, 0, 1'b1, "back_to_back_write");
      run_txn(0, 1'b0, 0, 64, 0, 1'b1, "back_to_back_read");
      test_reset_access();
      test_random();
      test_timeout();
      @(negedge clk);
      checks++;
      if (obs !== V_IDLE)
         $display("FAIL final_idle: got %b want %b", obs, V_IDLE);
      else
         passed++;
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/memory_access_controller.md
MEMORY_ACCESS_CONTROLLER -- requirements
Module: memory_access_controller

Interface
REQ-001 Parameter WAIT_STATES, default 1: minimum cycles spent in ACCESS before completion (0..255).
REQ-002 Parameter TIMEOUT_CYCLES, default 64: ACCESS cycles before abort when MEM_TIMEOUT_EN is defined (1..255).
REQ-003 in_clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 in_clr  input  1  synchronous, active-high reset.
REQ-005 in_start  input  1  request strobe from the control unit; sampled only in IDLE.
REQ-006 in_rw  input  1  0 = read (memory to MDR), 1 = write (MDR to memory); captured with in_start.
REQ-007 in_mem_ready  input  1  memory acknowledge; level-sampled in ACCESS.
REQ-008 out_mar_load  output  1  MAR load enable.
REQ-009 out_mdr_write  output  1  MDR load enable.
REQ-010 out_mdr_read  output  1  MDR mux select: 1 = memory, 0 = bus.
REQ-011 out_mem_read  output  1  memory read strobe.
REQ-012 out_mem_write  output  1  memory write strobe.
REQ-013 out_busy  output  1  high in every state except IDLE.
REQ-014 out_done  output  1  one-cycle completion pulse.
REQ-015 out_error  output  1  one-cycle abort pulse, coincident with out_done.

Function
REQ-016 The FSM SHALL have states IDLE, ADDR, ACCESS, LATCH, DONE; all outputs are Moore, decoded from the registered state only.
REQ-017 IDLE: all outputs 0; in_start=1 SHALL capture in_rw into an internal op bit and move to ADDR next cycle.
REQ-018 ADDR: out_mar_load=1 for exactly one cycle; clear the wait counter; go to ACCESS.
REQ-019 ACCESS: out_mem_read=1 if op=read, out_mem_write=1 if op=write; the 8-bit wait counter SHALL increment each cycle, saturating at 255.
REQ-020 ACCESS exit SHALL require in_mem_ready=1 AND counter >= WAIT_STATES; then go to LATCH for read, DONE for write.
REQ-021 LATCH: out_mdr_read=1 and out_mdr_write=1 for exactly one cycle; memory strobe deasserted; go to DONE.
REQ-022 DONE: out_done=1 for one cycle; go to IDLE.
REQ-023 Latency with WAIT_STATES=0 and in_mem_ready held high: read = 4 cycles, write = 3 cycles from the in_start-sampling edge to out_done asserted.
REQ-024 in_start and in_rw SHALL be ignored while out_busy=1; op SHALL NOT change mid-transaction.
REQ-025 A new in_start SHALL be accepted in the first IDLE cycle after DONE (back-to-back rate: one request per 5 cycles for reads, 4 for writes, minimum).
REQ-026 in_mem_ready outside ACCESS SHALL have no effect.
REQ-027 out_mdr_write SHALL never assert in write transactions; out_mem_read and out_mem_write SHALL never be high together.

Reset
REQ-028 in_clr=1 at a rising edge SHALL force IDLE, clear op, the wait counter, and the timeout counter; all outputs 0 the following cycle.
REQ-029 Reset SHALL take priority over in_start in the same cycle and SHALL abort any transaction in flight without out_done or out_error.

Configuration
REQ-030 Macro MEM_TIMEOUT_EN defined: if ACCESS has lasted TIMEOUT_CYCLES cycles without exit, the FSM SHALL go to DONE with out_error=1 asserted with out_done, skipping LATCH (MDR not loaded).
REQ-031 Macro MEM_TIMEOUT_EN undefined: ACCESS waits indefinitely; out_error SHALL be tied to 0; the port remains present.

Verification
REQ-032 Reset, then read, WAIT_STATES=0, in_mem_ready=1 -> mar_load at cycle 1, mem_read at cycle 2, mdr_read=mdr_write=1 at cycle 3, done at cycle 4.
REQ-033 Write, WAIT_STATES=2, in_mem_ready held high -> mem_write high cycles 2-4, done at cycle 5, mdr_write never high.
REQ-034 Read with in_mem_ready asserted 6 cycles into ACCESS -> mem_read held for 7 cycles, then LATCH, then done; in_start pulses during busy are ignored.
REQ-035 in_clr asserted during ACCESS -> next cycle IDLE, all outputs 0, no done; a subsequent read completes normally.
REQ-036 MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, in_mem_ready=0 -> 4 ACCESS cycles, then done=error=1 for one cycle, mdr_write never high; without the macro, busy remains high indefinitely.
